// File: rtl/sign_reducer.sv
// Signed wide-to-narrow reducer with saturate/wrap modes,
// one-deep output register and overflow statistics.
module sign_reducer #(
    parameter int REGISTER_DATA_BIT_WIDTH = 16,
    parameter int WIDE_DATA_WIDTH         = 32,
    parameter int OVF_COUNT_WIDTH         = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [WIDE_DATA_WIDTH-1:0]         data_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               wrap_mode,
    output logic [REGISTER_DATA_BIT_WIDTH-1:0] data_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               ovf,
    output logic                               ovf_sticky,
    output logic [OVF_COUNT_WIDTH-1:0]         ovf_count,
    input  logic                               clear_stats
);

    localparam int N = REGISTER_DATA_BIT_WIDTH;
    localparam int W = WIDE_DATA_WIDTH;
    localparam int C = OVF_COUNT_WIDTH;

    logic [W-N:0] top_bits;
    logic         fits;
    logic         sign;
    logic [N-1:0] sat_val;
    logic [N-1:0] result;
    logic         accept;
    logic         ovf_accept;

    // Value fits when every bit from the narrow sign bit upward agrees.
    assign top_bits   = data_in[W-1:N-1];
    assign fits       = (&top_bits) | ~(|top_bits);
    assign sign       = data_in[W-1];
    assign sat_val    = {sign, {(N-1){~sign}}};
    assign result     = (fits || wrap_mode) ? data_in[N-1:0] : sat_val;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign ovf_accept = accept && !fits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            ovf       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            data_out  <= result;
            ovf       <= !fits;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A clear in the same cycle as an overflow leaves exactly that one counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (clear_stats) begin
            ovf_sticky <= ovf_accept;
            ovf_count  <= ovf_accept ? C'(1) : '0;
        end else if (ovf_accept) begin
            ovf_sticky <= 1'b1;
            if (!(&ovf_count))
                ovf_count <= ovf_count + C'(1);
        end
    end

endmodule

// File: tb/tb_sign_reducer.sv
// Directed self-checking bench for sign_reducer
// at 16-bit narrow, 32-bit wide, 8-bit counter.
module tb_sign_reducer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic        wrap_mode;
    logic [15:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;
    logic        clear_stats;

    int checks = 0;
    int errors = 0;

    sign_reducer #(
        .REGISTER_DATA_BIT_WIDTH(16),
        .WIDE_DATA_WIDTH(32),
        .OVF_COUNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wrap_mode(wrap_mode),
        .data_out(data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovf(ovf),
        .ovf_sticky(ovf_sticky),
        .ovf_count(ovf_count),
        .clear_stats(clear_stats)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic w);
        data_in   = d;
        wrap_mode = w;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        data_in     = 32'h0001_0000;
        in_valid    = 1'b0;
        wrap_mode   = 1'b0;
        out_ready   = 1'b0;
        clear_stats = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b exp 0", out_valid);
        end
        checks++;
        if (data_out !== 16'h0000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_data got %h/%b exp 0000/0", data_out, ovf);
        end
        checks++;
        if (ovf_sticky !== 1'b0 || ovf_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_stats got %b/%0d exp 0/0", ovf_sticky, ovf_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got %b exp 1", in_ready);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst got rdy %b vld %b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_saturate_fit();
        out_ready = 1'b1;
        send(32'hFFFF_8000, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 16'h8000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL fit_neg got %b %h %b exp 1 8000 0", out_valid, data_out, ovf);
        end
        send(32'h0000_7FFF, 1'b0);
        checks++;
        if (data_out !== 16'h7FFF || ovf !== 1'b0) begin
            errors++;
            $display("FAIL fit_pos got %h %b exp 7fff 0", data_out, ovf);
        end
        checks++;
        if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL fit_stats got %0d %b exp 0 0", ovf_count, ovf_sticky);
        end
    endtask

    task automatic test_saturate_ovf();
        send(32'h0000_8000, 1'b0);
        checks++;
        if (data_out !== 16'h7FFF || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got %h %b exp 7fff 1", data_out, ovf);
        end
        send(32'h8000_0000, 1'b0);
        checks++;
        if (data_out !== 16'h8000 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg got %h %b exp 8000 1", data_out, ovf);
        end
        checks++;
        if (ovf_count !== 8'd2 || ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sat_stats got %0d %b exp 2 1", ovf_count, ovf_sticky);
        end
    endtask

    task automatic test_wrap();
        send(32'h0001_2345, 1'b1);
        checks++;
        if (data_out !== 16'h2345 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ovf got %h %b exp 2345 1", data_out, ovf);
        end
        send(32'hFFFF_FFFE, 1'b1);
        checks++;
        if (data_out !== 16'hFFFE || ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_fit got %h %b exp fffe 0", data_out, ovf);
        end
        checks++;
        if (ovf_count !== 8'd3) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 3", ovf_count);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain got %b exp 0", out_valid);
        end
    endtask

    task automatic test_invalid_ignored();
        data_in   = 32'h7000_0000;
        wrap_mode = 1'b0;
        in_valid  = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || ovf_count !== 8'd3 || data_out !== 16'hFFFE) begin
            errors++;
            $display("FAIL idle got %b %0d %h exp 0 3 fffe", out_valid, ovf_count, data_out);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(32'h0000_0011, 1'b0);
        data_in  = 32'h0000_0022;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || data_out !== 16'h0011 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall%0d got rdy %b data %h exp 0 0011", i, in_ready, data_out);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_rdy got %b exp 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || data_out !== 16'h0022) begin
            errors++;
            $display("FAIL b2b_1 got %b %h exp 1 0022", out_valid, data_out);
        end
        data_in = 32'h0000_0033;
        step();
        checks++;
        if (out_valid !== 1'b1 || data_out !== 16'h0033) begin
            errors++;
            $display("FAIL b2b_2 got %b %h exp 1 0033", out_valid, data_out);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got %b exp 0", out_valid);
        end
    endtask

    task automatic test_stats_no_ready();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        checks++;
        if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clear got %0d %b exp 0 0", ovf_count, ovf_sticky);
        end
        out_ready = 1'b0;
        send(32'hF000_0000, 1'b0);
        checks++;
        if (ovf_count !== 8'd1 || data_out !== 16'h8000) begin
            errors++;
            $display("FAIL noready got %0d %h exp 1 8000", ovf_count, data_out);
        end
        send(32'h0F00_0000, 1'b0);
        checks++;
        if (ovf_count !== 8'd1 || data_out !== 16'h8000) begin
            errors++;
            $display("FAIL blocked got %0d %h exp 1 8000", ovf_count, data_out);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_count_saturate();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        data_in     = 32'h0001_0000;
        wrap_mode   = 1'b1;
        in_valid    = 1'b1;
        for (int i = 0; i < 254; i++) step();
        checks++;
        if (ovf_count !== 8'd254) begin
            errors++;
            $display("FAIL cnt254 got %0d exp 254", ovf_count);
        end
        step();
        checks++;
        if (ovf_count !== 8'd255) begin
            errors++;
            $display("FAIL cnt255 got %0d exp 255", ovf_count);
        end
        for (int i = 0; i < 45; i++) step();
        checks++;
        if (ovf_count !== 8'd255 || ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL cnt300 got %0d %b exp 255 1", ovf_count, ovf_sticky);
        end
        clear_stats = 1'b1;
        step();
        checks++;
        if (ovf_count !== 8'd1 || ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL clr_ovf got %0d %b exp 1 1", ovf_count, ovf_sticky);
        end
        in_valid = 1'b0;
        step();
        clear_stats = 1'b0;
        checks++;
        if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clr_only got %0d %b exp 0 0", ovf_count, ovf_sticky);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(32'h0004_0000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || ovf_count !== 8'd1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst got %b %0d %b exp 1 1 1", out_valid, ovf_count, ovf);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ovf_count !== 8'd0 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got %b %0d %b exp 0 0 0", out_valid, ovf_count, ovf_sticky);
        end
        checks++;
        if (data_out !== 16'h0000 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_data got %h %b %b exp 0000 0 1", data_out, ovf, in_ready);
        end
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || data_out !== 16'h0000) begin
            errors++;
            $display("FAIL no_reappear got %b %h exp 0 0000", out_valid, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_saturate_fit();
        test_saturate_ovf();
        test_wrap();
        test_invalid_ignored();
        test_back_to_back();
        test_stats_no_ready();
        test_count_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_reducer.md
SIGN_REDUCER -- requirements
Module: sign_reducer

Interface
REQ-001 SHALL have parameter REGISTER_DATA_BIT_WIDTH, default 16, output (narrow) data width.
REQ-002 SHALL have parameter WIDE_DATA_WIDTH, default 32, input (wide) data width; values below REGISTER_DATA_BIT_WIDTH+1 are illegal.
REQ-003 SHALL have parameter OVF_COUNT_WIDTH, default 8, overflow counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 data_in  input  WIDE_DATA_WIDTH  signed two's-complement value to narrow.
REQ-008 in_valid  input  1  data_in/wrap_mode valid.
REQ-009 in_ready  output  1  block can accept input this cycle.
REQ-010 wrap_mode  input  1  1 = truncate, 0 = saturate; sampled with data_in.
REQ-011 data_out  output  REGISTER_DATA_BIT_WIDTH  narrowed result.
REQ-012 out_valid  output  1  data_out/ovf valid.
REQ-013 out_ready  input  1  consumer accepts data_out.
REQ-014 ovf  output  1  the held result did not fit; qualified by out_valid.
REQ-015 ovf_sticky  output  1  at least one overflow has been accepted since the last clear or reset.
REQ-016 ovf_count  output  OVF_COUNT_WIDTH  number of accepted overflowing inputs, saturating.
REQ-017 clear_stats  input  1  synchronous clear of ovf_sticky and ovf_count.

Function
REQ-018 Fit test: data_in fits iff bits [WIDE_DATA_WIDTH-1 : REGISTER_DATA_BIT_WIDTH-1] are all equal.
REQ-019 If the input fits, the result SHALL be data_in[REGISTER_DATA_BIT_WIDTH-1:0] and ovf SHALL be 0, in either mode.
REQ-020 If the input does not fit and wrap_mode=1, the result SHALL be data_in[REGISTER_DATA_BIT_WIDTH-1:0] and ovf SHALL be 1.
REQ-021 If the input does not fit and wrap_mode=0, the result SHALL be the maximum positive value (0x7FFF at 16 bits) when data_in[WIDE_DATA_WIDTH-1]=0, or the minimum negative value (0x8000 at 16 bits) when it is 1; ovf SHALL be 1.
REQ-022 A transfer in SHALL occur when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-023 Single output register, latency 1 cycle: data accepted at edge N SHALL appear with out_valid=1 after edge N.
REQ-024 in_ready SHALL be combinationally !out_valid || out_ready, so back-to-back transfers sustain 1 result per cycle.
REQ-025 While out_valid=1 && out_ready=0, data_out and ovf SHALL hold stable and in_ready SHALL be 0.
REQ-026 out_valid SHALL clear after a transfer out that has no simultaneous transfer in; on a simultaneous transfer in and out, the output register SHALL reload with out_valid remaining 1.
REQ-027 Inputs presented with in_valid=0 SHALL have no effect on any state.
REQ-028 ovf_count SHALL increment on each accepted input that does not fit, and SHALL saturate at 2^OVF_COUNT_WIDTH-1 without wrapping.
REQ-029 ovf_sticky SHALL set on each accepted input that does not fit.
REQ-030 clear_stats=1 SHALL zero ovf_sticky and ovf_count at the next edge.
REQ-031 If clear_stats=1 and an overflowing input is accepted in the same cycle, the next state SHALL be ovf_sticky=1, ovf_count=1.
REQ-032 Statistics SHALL update at acceptance, independent of the state of out_ready.

Reset
REQ-033 rst_n=0 SHALL immediately force out_valid=0, data_out=0, ovf=0, ovf_sticky=0 and ovf_count=0, regardless of clk.
REQ-034 A result held at the time rst_n is asserted SHALL be discarded, and SHALL NOT reappear after release.
REQ-035 in_ready SHALL be 1 during reset and on the first cycle after release.

Verification (REGISTER_DATA_BIT_WIDTH=16, WIDE_DATA_WIDTH=32, OVF_COUNT_WIDTH=8)
REQ-036 Inputs 0xFFFF8000 and 0x00007FFF in saturate mode -> outputs 0x8000 and 0x7FFF, ovf=0, ovf_count=0.
REQ-037 Inputs 0x00008000 and 0x80000000 in saturate mode -> outputs 0x7FFF and 0x8000, ovf=1 each, ovf_count=2, ovf_sticky=1.
REQ-038 Input 0x00012345 with wrap_mode=1 -> output 0x2345, ovf=1.
REQ-039 Back-to-back inputs with out_ready=0 for 3 cycles -> in_ready=0 and data_out stable for those 3 cycles; after out_ready=1, one result per cycle with no loss or duplication.
REQ-040 300 overflowing inputs -> ovf_count=255; clear_stats together with a further overflow in the same cycle -> ovf_count=1, ovf_sticky=1.
REQ-041 rst_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0 and ovf_count=0 before the next clk edge, and the held result never reappears.
